// File: rtl/safe_pkg.sv
// Shared definitions for the safe keypad controller.
// Holds the controller state encoding, the non-digit key codes and the
// fixed LCD patterns shown in each state.
package safe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam logic [7:0] DISP_IDLE = 8'h00;
  localparam logic [7:0] DISP_OPEN = 8'hAA;
  localparam logic [7:0] DISP_FAIL = 8'hEE;
  localparam logic [7:0] DISP_LOCK = 8'hFF;

  // Keys 0..9 are digits; A/B are commands; C..F carry no meaning.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Loadable 16-bit down-counter shared by every timed controller state.
// Ports:
//   clk_1ms  in   1 ms clock
//   reset    in   asynchronous active-low reset
//   load     in   reload the counter with value this cycle
//   value    in   reload value (number of cycles until expiry)
//   expired  out  high for exactly one cycle, the last cycle of the
//                 loaded interval, so the owner can leave on that edge
module ms_timer (
  input  logic        clk_1ms,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic        expired
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loading N gives N cycles: the count sits at 1 on the final cycle and
  // then parks at 0, so a stale count can never re-fire.
  assign expired = (cnt_q == 16'd1);

endmodule

// File: rtl/safe_code_entry.sv
// Four-digit keypad safe controller.
// Ports:
//   clk_1ms    in   sole clock, 1 ms period
//   reset      in   asynchronous active-low reset
//   key_valid  in   one-cycle strobe qualifying key_code
//   key_code   in   0..9 digit, A clear, B enter, C..F ignored
//   data       out  two nibbles for the LCD driver, [7:4] left character
//   blank      out  LCD shows a blank field
//   unlocked   out  bolt release, high only while open
//   alarm      out  high only during lockout
module safe_code_entry
  import safe_pkg::*;
#(
  parameter logic [15:0] CODE       = 16'h1234,
  parameter int unsigned MAX_FAIL   = 3,
  parameter int unsigned IDLE_MS    = 8000,
  parameter int unsigned UNLOCK_MS  = 5000,
  parameter int unsigned FAIL_MS    = 1000,
  parameter int unsigned LOCKOUT_MS = 10000
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] data,
  output logic       blank,
  output logic       unlocked,
  output logic       alarm
);

  localparam logic [15:0] IDLE_LD   = 16'(IDLE_MS);
  localparam logic [15:0] UNLOCK_LD = 16'(UNLOCK_MS);
  localparam logic [15:0] FAIL_LD   = 16'(FAIL_MS);
  localparam logic [15:0] LOCK_LD   = 16'(LOCKOUT_MS);
  localparam logic [2:0]  MAX_FAIL_L = 3'(MAX_FAIL);

  state_e      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  fail_q, fail_d;
  logic [7:0]  data_q, data_d;
  logic        blank_q, blank_d;
  logic        unlocked_q, unlocked_d;
  logic        alarm_q, alarm_d;

  logic        tmr_load;
  logic [15:0] tmr_value;
  logic        tmr_expired;
  logic [2:0]  fail_inc;

  ms_timer u_timer (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    tmr_load  = 1'b0;
    tmr_value = 16'd0;
    // Saturating increment: the counter must never wrap back to zero.
    fail_inc  = (fail_q == 3'd7) ? fail_q : fail_q + 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (key_valid && is_digit(key_code)) begin
          state_d   = ST_ENTRY;
          buf_d     = {buf_q[11:0], key_code};
          cnt_d     = 3'd1;
          tmr_load  = 1'b1;
          tmr_value = IDLE_LD;
        end
      end
      ST_ENTRY: begin
        // A key on the expiry cycle wins: it reloads the timer instead.
        if (key_valid) begin
          tmr_load  = 1'b1;
          tmr_value = IDLE_LD;
          if (is_digit(key_code)) begin
            if (cnt_q < 3'd4) begin
              buf_d = {buf_q[11:0], key_code};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            buf_d = 16'd0;
            cnt_d = 3'd0;
          end else if (key_code == KEY_ENTER) begin
            state_d = ST_CHECK;
          end
        end else if (tmr_expired) begin
          state_d = ST_IDLE;
          buf_d   = 16'd0;
          cnt_d   = 3'd0;
        end
      end
      ST_CHECK: begin
        buf_d    = 16'd0;
        cnt_d    = 3'd0;
        tmr_load = 1'b1;
        if (cnt_q == 3'd4 && buf_q == CODE) begin
          state_d   = ST_OPEN;
          fail_d    = 3'd0;
          tmr_value = UNLOCK_LD;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == MAX_FAIL_L) begin
            state_d   = ST_LOCKOUT;
            tmr_value = LOCK_LD;
          end else begin
            state_d   = ST_FAIL;
            tmr_value = FAIL_LD;
          end
        end
      end
      ST_OPEN: begin
        if ((key_valid && key_code == KEY_CLEAR) || tmr_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
          fail_d  = 3'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        buf_d   = 16'd0;
        cnt_d   = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge that accepts the key or moves the state.
    data_d     = DISP_IDLE;
    blank_d    = 1'b1;
    unlocked_d = 1'b0;
    alarm_d    = 1'b0;
    case (state_d)
      ST_ENTRY, ST_CHECK: begin
        data_d  = buf_d[7:0];
        blank_d = 1'b0;
      end
      ST_OPEN: begin
        data_d     = DISP_OPEN;
        blank_d    = 1'b0;
        unlocked_d = 1'b1;
      end
      ST_FAIL: begin
        data_d  = DISP_FAIL;
        blank_d = 1'b0;
      end
      ST_LOCKOUT: begin
        data_d  = DISP_LOCK;
        blank_d = 1'b0;
        alarm_d = 1'b1;
      end
      default: begin
        data_d  = DISP_IDLE;
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= 16'd0;
      cnt_q      <= 3'd0;
      fail_q     <= 3'd0;
      data_q     <= DISP_IDLE;
      blank_q    <= 1'b1;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      data_q     <= data_d;
      blank_q    <= blank_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign data     = data_q;
  assign blank    = blank_q;
  assign unlocked = unlocked_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_safe_code_entry.sv
// Self-checking bench for safe_code_entry: a behavioural model (digit
// queue plus remaining-time counter) is compared against the outputs every
// cycle, and directed scenarios pin timings and display values literally.
module tb_safe_code_entry;

  localparam logic [15:0] CODE       = 16'h1234;
  localparam int          MAX_FAIL   = 3;
  localparam int          IDLE_MS    = 8000;
  localparam int          UNLOCK_MS  = 5000;
  localparam int          FAIL_MS    = 1000;
  localparam int          LOCKOUT_MS = 10000;

  logic       clk_1ms = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] data;
  logic       blank;
  logic       unlocked;
  logic       alarm;

  int tests = 0;
  int fails = 0;

  safe_code_entry #(
    .CODE(CODE), .MAX_FAIL(MAX_FAIL), .IDLE_MS(IDLE_MS),
    .UNLOCK_MS(UNLOCK_MS), .FAIL_MS(FAIL_MS), .LOCKOUT_MS(LOCKOUT_MS)
  ) dut (
    .clk_1ms   (clk_1ms),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .data      (data),
    .blank     (blank),
    .unlocked  (unlocked),
    .alarm     (alarm)
  );

  always #5 clk_1ms = ~clk_1ms;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {20'h0, data, blank, unlocked, alarm};
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_FAIL = 4, M_LOCK = 5;
  int         m_mode;
  int         m_left;
  int         m_fails;
  logic [3:0] m_digits[$];

  task automatic model_reset();
    m_mode = M_IDLE;
    m_left = 0;
    m_fails = 0;
    m_digits.delete();
  endtask

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + int'(m_digits[i]);
    return v;
  endfunction

  task automatic model_step(input logic kv, input logic [3:0] kc);
    case (m_mode)
      M_IDLE: if (kv && kc <= 4'd9) begin
        m_digits.delete();
        m_digits.push_back(kc);
        m_mode = M_ENTRY;
        m_left = IDLE_MS;
      end
      M_ENTRY: begin
        if (kv) begin
          m_left = IDLE_MS;
          if (kc <= 4'd9) begin
            if (m_digits.size() < 4) m_digits.push_back(kc);
          end else if (kc == 4'hA) m_digits.delete();
          else if (kc == 4'hB) m_mode = M_CHECK;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE;
            m_digits.delete();
          end
        end
      end
      M_CHECK: begin
        if (m_digits.size() == 4 && digits_value() == int'(CODE)) begin
          m_mode = M_OPEN; m_fails = 0; m_left = UNLOCK_MS;
        end else begin
          m_fails++;
          if (m_fails == MAX_FAIL) begin m_mode = M_LOCK; m_left = LOCKOUT_MS; end
          else begin m_mode = M_FAIL; m_left = FAIL_MS; end
        end
        m_digits.delete();
      end
      M_OPEN: begin
        if (kv && kc == 4'hA) m_mode = M_IDLE;
        else begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
      end
      M_FAIL: begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_IDLE; m_fails = 0; end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Per-cycle compare of the DUT against the model, 1 time unit after each edge.
  initial begin
    logic [15:0] v;
    logic [7:0]  ed;
    logic        eb, eu, ea;
    model_reset();
    forever begin
      @(posedge clk_1ms);
      if (!reset) model_reset();
      else model_step(key_valid, key_code);
      #1;
      if (!reset) model_reset();
      ed = 8'h00; eb = 1'b1; eu = 1'b0; ea = 1'b0;
      case (m_mode)
        M_ENTRY: begin v = 16'(digits_value()); ed = v[7:0]; eb = 1'b0; end
        M_OPEN:  begin ed = 8'hAA; eb = 1'b0; eu = 1'b1; end
        M_FAIL:  begin ed = 8'hEE; eb = 1'b0; end
        M_LOCK:  begin ed = 8'hFF; eb = 1'b0; ea = 1'b1; end
        default: ;
      endcase
      if (m_mode == M_CHECK)
        check("cyc_check_flags", 32'({unlocked, alarm}), 32'd0);
      else
        check("cyc_outputs", outs(), {20'h0, ed, eb, eu, ea});
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [3:0] k);
    @(negedge clk_1ms);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk_1ms);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Counts consecutive cycles (sampled at negedges) in which the chosen
  // condition holds; optionally strobes assorted keys while counting.
  task automatic measure(input int sel, input bit poke, output int n);
    bit c;
    n = 0;
    for (int i = 0; i < 20000; i++) begin
      case (sel)
        0:       c = (unlocked === 1'b1) && (data === 8'hAA);
        1:       c = (data === 8'hEE) && (unlocked === 1'b0) && (blank === 1'b0);
        default: c = (alarm === 1'b1) && (data === 8'hFF);
      endcase
      if (!c) break;
      n++;
      if (poke && (n % 97 == 0)) begin
        key_valid = 1'b1;
        key_code  = 4'(n % 16);
      end else begin
        key_valid = 1'b0;
        key_code  = 4'h0;
      end
      @(negedge clk_1ms);
    end
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  initial begin
    int n;
    reset = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    repeat (3) @(negedge clk_1ms);
    check("reset_outputs", outs(), {20'h0, 8'h00, 1'b1, 1'b0, 1'b0});

    // Correct code; first key lands on the first edge after release.
    reset = 1'b1; key_valid = 1'b1; key_code = 4'd1;
    @(negedge clk_1ms);
    key_valid = 1'b0; key_code = 4'h0;
    check("first_key_data", 32'({data, blank}), 32'({8'h01, 1'b0}));
    press(4'd2); check("data_12", 32'(data), 32'h12);
    press(4'd3); check("data_23", 32'(data), 32'h23);
    press(4'd4); check("data_34", 32'(data), 32'h34);
    press(4'hB); check("check_not_open", 32'(unlocked), 32'd0);
    @(negedge clk_1ms);
    measure(0, 1'b0, n);
    check("open_cycles", 32'(n), 32'd5000);
    check("after_open_blank", 32'({blank, unlocked}), 32'({1'b1, 1'b0}));

    // Short code -> FAIL.
    press(4'd1); press(4'd2); press(4'd3); press(4'hB);
    @(negedge clk_1ms);
    measure(1, 1'b1, n);
    check("fail_cycles", 32'(n), 32'd1000);

    // Two more wrong codes -> LOCKOUT, keys ignored throughout.
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'hB);
    @(negedge clk_1ms);
    measure(1, 1'b0, n);
    check("fail2_cycles", 32'(n), 32'd1000);
    press(4'd1); press(4'd2); press(4'hB);
    @(negedge clk_1ms);
    measure(2, 1'b1, n);
    check("lockout_cycles", 32'(n), 32'd10000);
    check("after_lock", 32'({alarm, blank}), 32'({1'b0, 1'b1}));
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
    @(negedge clk_1ms);
    check("open_after_lock", 32'({unlocked, data}), 32'({1'b1, 8'hAA}));
    press(4'd5);
    check("open_digit_ignored", 32'(unlocked), 32'd1);
    press(4'hA);
    check("open_clear_exit", 32'({blank, unlocked}), 32'({1'b1, 1'b0}));

    // Fifth digit ignored, clear, then idle timeout.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("fifth_ignored", 32'(data), 32'h34);
    press(4'hA);
    check("clear_data", 32'({data, blank}), 32'({8'h00, 1'b0}));
    n = 0;
    while (blank === 1'b0 && n < 20000) begin
      @(negedge clk_1ms);
      n++;
    end
    check("idle_expiry_cycles", 32'(n), 32'd8000);

    // Key on the exact expiry cycle keeps ENTRY and reloads the timer.
    press(4'd5);
    repeat (7999) @(negedge clk_1ms);
    check("pre_expiry_entry", 32'(blank), 32'd0);
    key_valid = 1'b1; key_code = 4'd6;
    @(negedge clk_1ms);
    key_valid = 1'b0; key_code = 4'h0;
    check("expiry_key_wins", 32'({data, blank}), 32'({8'h56, 1'b0}));
    repeat (7999) @(negedge clk_1ms);
    check("reloaded_entry", 32'(blank), 32'd0);
    @(negedge clk_1ms);
    check("reloaded_expiry", 32'(blank), 32'd1);

    // Asynchronous reset in the middle of OPEN.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
    repeat (50) @(negedge clk_1ms);
    check("mid_open", 32'(unlocked), 32'd1);
    #2 reset = 1'b0;
    #1 check("async_reset", outs(), {20'h0, 8'h00, 1'b1, 1'b0, 1'b0});
    @(negedge clk_1ms);
    reset = 1'b1;
    @(negedge clk_1ms);
    check("post_reset_idle", 32'({blank, unlocked}), 32'({1'b1, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/safe_code_entry.md
SAFE_CODE_ENTRY -- requirements
Module: safe_code_entry

Interface
REQ-001 Parameter: CODE, 16'h1234, unlock code as four BCD digits, MS digit first.
REQ-002 Parameter: MAX_FAIL, 3, consecutive wrong codes that trigger lockout (range 1..7).
REQ-003 Parameter: IDLE_MS, 8000, clk_1ms cycles without a key in ENTRY before returning to IDLE.
REQ-004 Parameter: UNLOCK_MS, 5000, cycles spent in OPEN.
REQ-005 Parameter: FAIL_MS, 1000, cycles spent in FAIL.
REQ-006 Parameter: LOCKOUT_MS, 10000, cycles spent in LOCKOUT; all timing parameters SHALL be 1..65535.
REQ-007 Port: clk_1ms  in  1  sole clock, 1 ms period, all state on rising edge.
REQ-008 Port: reset  in  1  asynchronous, active-low reset.
REQ-009 Port: key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-010 Port: key_code  in  4  0..9 digit, 4'hA clear, 4'hB enter, 4'hC..4'hF ignored.
REQ-011 Port: data  out  8  two hex nibbles for the LCD driver, [7:4] left character.
REQ-012 Port: blank  out  1  1 = LCD driver shows blank field.
REQ-013 Port: unlocked  out  1  bolt release, high only in OPEN.
REQ-014 Port: alarm  out  1  high only in LOCKOUT.

Function
REQ-015 FSM states SHALL be IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT; all outputs registered, updated on the edge that accepts a key or changes state (one-cycle latency).
REQ-016 IDLE: blank=1, data=8'h00; digit key -> ENTRY with digit shifted in, count=1; clear/enter ignored.
REQ-017 ENTRY: digit key shifts 16-bit buffer left 4 bits and inserts digit while count<4, count+1; when count=4 further digits ignored (buffer unchanged).
REQ-018 ENTRY: data=buffer[7:0], blank=0; clear -> buffer=0, count=0, remain ENTRY.
REQ-019 ENTRY: enter -> CHECK; idle timer reloaded by every accepted key_valid, expiry after IDLE_MS keyless cycles -> IDLE with buffer and count cleared.
REQ-020 Key strobe and idle expiry in the same cycle: key wins, timer reloads.
REQ-021 CHECK lasts exactly one cycle; match = (count==4 && buffer==CODE).
REQ-022 Match -> OPEN, fail counter cleared; mismatch -> fail counter +1, LOCKOUT if new value == MAX_FAIL, else FAIL; buffer and count cleared on exit.
REQ-023 OPEN: unlocked=1, data=8'hAA, blank=0, exactly UNLOCK_MS cycles then IDLE; clear key -> IDLE immediately; other keys ignored.
REQ-024 FAIL: data=8'hEE, blank=0, exactly FAIL_MS cycles then IDLE; all keys ignored.
REQ-025 LOCKOUT: alarm=1, data=8'hFF, blank=0, exactly LOCKOUT_MS cycles then IDLE with fail counter cleared; all keys ignored.
REQ-026 key_valid during CHECK ignored; fail counter 3 bits, never wraps.

Reset
REQ-027 reset low SHALL immediately force IDLE, data=8'h00, blank=1, unlocked=0, alarm=0, buffer=0, count=0, fail counter=0, timer=0, including mid-OPEN or mid-LOCKOUT.
REQ-028 After reset release the first accepted key is the one on the first rising edge with reset high.

Structure
REQ-029 Shared package safe_pkg SHALL hold state encoding, key codes (KEY_CLEAR=4'hA, KEY_ENTER=4'hB) and display constants (DISP_OPEN=8'hAA, DISP_FAIL=8'hEE, DISP_LOCK=8'hFF).
REQ-030 One sub-module ms_timer: 16-bit loadable down-counter, load/value inputs, one-cycle expired output; single instance shared by all timed states.

Verification
REQ-031 Reset, keys 1,2,3,4,enter -> data 8'h01,8'h12,8'h23,8'h34; CHECK one cycle; unlocked=1, data=8'hAA for 5000 cycles, then blank=1.
REQ-032 Keys 1,2,3,enter -> FAIL, data=8'hEE for 1000 cycles, unlocked stays 0.
REQ-033 Three consecutive wrong codes -> alarm=1, data=8'hFF for 10000 cycles; keys ignored; afterwards correct code opens.
REQ-034 Keys 1,2,3,4,5 -> data 8'h34 (5 ignored); clear -> data 8'h00; no key for 8000 cycles -> blank=1.
REQ-035 Key on the exact idle-expiry cycle -> stays ENTRY; reset low mid-OPEN -> unlocked=0, blank=1 without waiting for a clock edge.
